// File: rtl/loadstore32_if.sv
// Bus bundle for loadstore32: pipeline request/result signals and the
// data-RAM request/acknowledge port. "master" is the LSU side.
interface loadstore32_if #(
  parameter int ADDR_W = 14
) ();
  logic              start;
  logic              is_store;
  logic [1:0]        size;
  logic              unsigned_ld;
  logic [31:0]       ALU_Result;
  logic [31:0]       Read_data_2;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       load_data;

  modport master (
    input  start, is_store, size, unsigned_ld, ALU_Result, Read_data_2,
    input  mem_ack, mem_rdata,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output busy, done, err, load_data
  );

  modport slave (
    output start, is_store, size, unsigned_ld, ALU_Result, Read_data_2,
    output mem_ack, mem_rdata,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  busy, done, err, load_data
  );
endinterface

// File: rtl/loadstore32.sv
// Multi-cycle byte/halfword/word load/store unit with request/ack RAM port and timeout.
// Optional alignment checking is enabled by defining LSU_ALIGN_CHECK_EN.
module loadstore32 #(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 15
) (
  input logic           clock,
  input logic           reset,
  loadstore32_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  function automatic logic [3:0] lane_enables(input logic [1:0] sz, input logic [1:0] o);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << o;
      2'b01:   be = o[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [1:0] sz, input logic [31:0] rt);
    logic [31:0] w;
    case (sz)
      2'b00:   w = {4{rt[7:0]}};
      2'b01:   w = {2{rt[15:0]}};
      default: w = rt;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] o, input logic uns);
    logic [31:0] sh;
    logic [31:0] r;
    case (sz)
      2'b00: begin
        sh = w >> {o, 3'b000};
        r  = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sh = w >> {o[1], 4'b0000};
        r  = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      default: begin
        sh = w;
        r  = sh;
      end
    endcase
    return r;
  endfunction

  state_t            state_r, state_nxt_s;
  logic              mem_req_r, mem_req_nxt_s;
  logic              mem_we_r, mem_we_nxt_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_nxt_s;
  logic [3:0]        mem_be_r, mem_be_nxt_s;
  logic [31:0]       mem_wdata_r, mem_wdata_nxt_s;
  logic [1:0]        size_r, size_nxt_s;
  logic [1:0]        off_r, off_nxt_s;
  logic              uns_r, uns_nxt_s;
  logic [7:0]        cnt_r, cnt_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              done_r, done_nxt_s;
  logic              err_r, err_nxt_s;
  logic [31:0]       load_data_r, load_data_nxt_s;
  logic [1:0]        off_s;
  logic              misalign_s;
  logic              unused_s;

  // Address bits above the RAM window are intentionally dropped.
  assign unused_s = ^bus.ALU_Result[31:ADDR_W+2];

`ifdef LSU_ALIGN_CHECK_EN
  // Flag halfword/word requests whose offset is not a multiple of the size.
  always_comb begin
    off_s = bus.ALU_Result[1:0];
    case (bus.size)
      2'b00:   misalign_s = 1'b0;
      2'b01:   misalign_s = bus.ALU_Result[0];
      default: misalign_s = |bus.ALU_Result[1:0];
    endcase
  end
`else
  // Force offset bits below the access size to zero.
  always_comb begin
    misalign_s = 1'b0;
    case (bus.size)
      2'b00:   off_s = bus.ALU_Result[1:0];
      2'b01:   off_s = {bus.ALU_Result[1], 1'b0};
      default: off_s = 2'b00;
    endcase
  end
`endif

  // Next-state and next-output logic for the IDLE/ACCESS/DONE sequencer.
  always_comb begin
    state_nxt_s     = state_r;
    mem_req_nxt_s   = mem_req_r;
    mem_we_nxt_s    = mem_we_r;
    mem_addr_nxt_s  = mem_addr_r;
    mem_be_nxt_s    = mem_be_r;
    mem_wdata_nxt_s = mem_wdata_r;
    size_nxt_s      = size_r;
    off_nxt_s       = off_r;
    uns_nxt_s       = uns_r;
    cnt_nxt_s       = cnt_r;
    done_nxt_s      = 1'b0;
    err_nxt_s       = err_r;
    load_data_nxt_s = load_data_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          size_nxt_s      = bus.size;
          off_nxt_s       = off_s;
          uns_nxt_s       = bus.unsigned_ld;
          mem_addr_nxt_s  = bus.ALU_Result[ADDR_W+1:2];
          mem_be_nxt_s    = lane_enables(bus.size, off_s);
          mem_wdata_nxt_s = lane_replicate(bus.size, bus.Read_data_2);
          if (misalign_s) begin
            state_nxt_s  = DONE;
            mem_we_nxt_s = 1'b0;
            done_nxt_s   = 1'b1;
            err_nxt_s    = 1'b1;
          end else begin
            state_nxt_s   = ACCESS;
            mem_req_nxt_s = 1'b1;
            mem_we_nxt_s  = bus.is_store;
            cnt_nxt_s     = TIMEOUT_C;
            err_nxt_s     = 1'b0;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        // An ack in the expiry cycle still wins over the timeout.
        if (bus.mem_ack) begin
          state_nxt_s   = DONE;
          mem_req_nxt_s = 1'b0;
          mem_we_nxt_s  = 1'b0;
          done_nxt_s    = 1'b1;
          err_nxt_s     = 1'b0;
          if (!mem_we_r) begin
            load_data_nxt_s = load_extract(bus.mem_rdata, size_r, off_r, uns_r);
          end else begin
            load_data_nxt_s = load_data_r;
          end
        end else if (cnt_r == 8'd1) begin
          state_nxt_s   = DONE;
          mem_req_nxt_s = 1'b0;
          mem_we_nxt_s  = 1'b0;
          done_nxt_s    = 1'b1;
          err_nxt_s     = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 8'd1;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
        err_nxt_s   = 1'b0;
      end
      default: begin
        state_nxt_s   = IDLE;
        mem_req_nxt_s = 1'b0;
        mem_we_nxt_s  = 1'b0;
      end
    endcase
    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // State and output registers; reset clears every output including load_data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_be_r    <= 4'b0000;
      mem_wdata_r <= 32'h0000_0000;
      size_r      <= 2'b00;
      off_r       <= 2'b00;
      uns_r       <= 1'b0;
      cnt_r       <= 8'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      load_data_r <= 32'h0000_0000;
    end else begin
      state_r     <= state_nxt_s;
      mem_req_r   <= mem_req_nxt_s;
      mem_we_r    <= mem_we_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_be_r    <= mem_be_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      size_r      <= size_nxt_s;
      off_r       <= off_nxt_s;
      uns_r       <= uns_nxt_s;
      cnt_r       <= cnt_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      err_r       <= err_nxt_s;
      load_data_r <= load_data_nxt_s;
    end
  end

  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_be    = mem_be_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.load_data = load_data_r;

endmodule

// File: doc/loadstore32.md
# loadstore32

Multi-cycle load/store unit that sits directly downstream of the 32-bit execute stage. It takes the ALU result as the effective address and the second register operand as store data, then runs a request/acknowledge transaction against the data RAM. It handles byte, halfword and word accesses: byte-enable generation, store-lane replication, and load extraction with sign or zero extension. It raises `busy` so the pipeline stalls while an access is in flight.

## Interface
- `ADDR_W`, 14, word-address width driven to the RAM (byte address bits [ADDR_W+1:2])
- `TIMEOUT`, 15, maximum cycles waited for `mem_ack` before abort; range 1..255
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  access request, sampled only in IDLE
- `is_store`  in  1  1 = store, 0 = load
- `size`  in  2  00 byte, 01 halfword, 11 word; 10 is treated as word
- `unsigned_ld`  in  1  1 = zero-extend a load (lbu/lhu)
- `ALU_Result`  in  32  effective byte address from the execute stage
- `Read_data_2`  in  32  store data (rt)
- `mem_req`  out  1  RAM request, held until ack or abort
- `mem_we`  out  1  RAM write enable, qualified by `mem_req`
- `mem_addr`  out  ADDR_W  RAM word address
- `mem_be`  out  4  byte enables; bit i = byte lane [8i+7:8i]
- `mem_wdata`  out  32  lane-replicated store data
- `mem_ack`  in  1  RAM completion; `mem_rdata` is valid in the same cycle
- `mem_rdata`  in  32  RAM read word
- `busy`  out  1  high whenever state is not IDLE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  valid with `done`: timeout or misalignment
- `load_data`  out  32  extended load result, held until the next load completes

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE, `start`=1:
  - Register the request fields.
  - Go to ACCESS; with alignment checking, a misaligned request goes to DONE instead.
- IDLE, `start`=0: stay in IDLE.
- ACCESS:
  - Drive `mem_req`=1 and load the timeout counter with TIMEOUT.
  - Each cycle without `mem_ack`, decrement the counter.
  - On `mem_ack`: capture and extend `mem_rdata` (loads only) and go to DONE with `err`=0.
  - Counter reaching 0 without ack: drop `mem_req` and go to DONE with `err`=1; `load_data` is unchanged.
- DONE: `done`=1 for exactly one cycle, then return to IDLE.
- A `start` seen in any state other than IDLE is ignored; the pipeline must hold it via `busy`.
- Byte enables and store data, with `o` = `ALU_Result[1:0]`:
  - Byte: `mem_be` = 1<<o; `mem_wdata` = {4{rt[7:0]}}.
  - Halfword: `mem_be` = o[1] ? 1100 : 0011; `mem_wdata` = {2{rt[15:0]}}.
  - Word: `mem_be` = 1111; `mem_wdata` = rt.
- Load extraction:
  - Select the lane `mem_rdata` >> (8·o) for bytes, or >> (16·o[1]) for halfwords.
  - Sign-extend from bit 7 or bit 15 unless `unsigned_ld`=1, in which case zero-extend.
- `mem_be` is driven on loads as well; the RAM may ignore it.
- Address bits above ADDR_W+1 are dropped; the address wraps inside the RAM window.

## Timing
- Reset value of every output is 0, including `load_data`. State returns to IDLE.
- Reset asserted mid-ACCESS drops `mem_req` asynchronously. A late `mem_ack` is then ignored.
- Latency from the `start` cycle (cycle 0):
  - `mem_req` rises in cycle 1.
  - An ack in cycle 1+k gives `done` in cycle 2+k.
  - Minimum latency is 2 cycles.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- `mem_req`, `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` are registered and stable for the whole ACCESS state.
- Timeout: with no ack, `mem_req` stays high for exactly TIMEOUT cycles, and `done` with `err`=1 follows in the next cycle.
- `mem_ack` arriving in the same cycle the counter expires counts as success.
- `mem_ack` outside ACCESS is ignored.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - Misaligned accesses are halfword with o[0]=1, or word with o≠0.
  - A misaligned access issues no `mem_req` and goes IDLE→DONE, so `done`=1 with `err`=1 in cycle 1.
  - A store leaves memory untouched; a load leaves `load_data` unchanged.
- `LSU_ALIGN_CHECK_EN` undefined:
  - Offset bits below the access size are forced to 0 (halfword clears o[0]; word clears o).
  - `err` reports timeout only.

## Test plan
- Store word 0x12345678 to 0x100, then load word from 0x100, RAM acks after 1 cycle → `mem_be`=1111, `mem_addr`=0x40, `load_data`=0x12345678, `done` in cycle 2.
- Store byte 0x80 to 0x103, then lb from 0x103 → `mem_be`=1000, `mem_wdata`=0x80808080, `load_data`=0xFFFFFF80; lbu from 0x103 → 0x00000080.
- Load halfword from 0x102 with RAM word 0x8001_7FFF → lh gives 0xFFFF8001, lhu gives 0x00008001.
- Halfword load from 0x101:
  - `LSU_ALIGN_CHECK_EN` on → no `mem_req`, `done`=1 with `err`=1 in cycle 1.
  - Off → address 0x100, `err`=0.
- RAM never acks, TIMEOUT=15 → `mem_req` high for cycles 1–15, `done`=1 with `err`=1 in cycle 16; `start` pulses during cycles 1–16 produce no second access.
- Reset pulled low in cycle 3 of an ack-delayed load → `mem_req`, `busy` and `done` drop to 0 immediately; a `mem_ack` 2 cycles after release is ignored and the next `start` proceeds normally.
